// File: rtl/alu_op_sequencer.sv
// Sequences one operation at a time through an external combinational ALU:
// registers operands, waits SETTLE_CYCLES (legal 1..15), then captures result and flags.
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reqValid,
  output logic       reqReady,
  input  logic [7:0] reqA,
  input  logic [7:0] reqB,
  input  logic [2:0] reqFunc,
  input  logic       reqCarry,
  input  logic       reqChain,
  output logic [7:0] aluA,
  output logic [7:0] aluB,
  output logic [2:0] aluFunc,
  output logic       aluCarryIn,
  input  logic [7:0] aluResult,
  input  logic       aluCarryOut,
  input  logic       aluZero,
  input  logic       aluNegative,
  output logic       respValid,
  input  logic       respReady,
  output logic [7:0] respResult,
  output logic       respCarry,
  output logic       respZero,
  output logic       respNegative,
  output logic       flagC,
  output logic       flagZ,
  output logic       flagN,
  input  logic       flagClear,
  output logic [7:0] opCount
);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] alu_a_q, alu_a_d;
  logic [7:0] alu_b_q, alu_b_d;
  logic [2:0] alu_func_q, alu_func_d;
  logic       alu_cin_q, alu_cin_d;
  logic [7:0] resp_result_q, resp_result_d;
  logic       resp_c_q, resp_c_d;
  logic       resp_z_q, resp_z_d;
  logic       resp_n_q, resp_n_d;
  logic       flag_c_q, flag_c_d;
  logic       flag_z_q, flag_z_d;
  logic       flag_n_q, flag_n_d;
  logic [7:0] op_count_q, op_count_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every comb output gets a default before the case, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (reqValid) state_d = SETTLE;
      SETTLE:  if (cnt_q == 4'd1) state_d = RESP;
      RESP:    if (respReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    reqReady  = (state_q == IDLE);
    respValid = (state_q == RESP);
  end

  always_comb begin
    cnt_d         = cnt_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_func_d    = alu_func_q;
    alu_cin_d     = alu_cin_q;
    resp_result_d = resp_result_q;
    resp_c_d      = resp_c_q;
    resp_z_d      = resp_z_q;
    resp_n_d      = resp_n_q;
    flag_c_d      = flag_c_q;
    flag_z_d      = flag_z_q;
    flag_n_d      = flag_n_q;
    op_count_d    = op_count_q;
    case (state_q)
      IDLE: begin
        if (flagClear) {flag_c_d, flag_z_d, flag_n_d} = 3'b000;
        if (reqValid) begin
          alu_a_d    = reqA;
          alu_b_d    = reqB;
          alu_func_d = reqFunc;
          // A same-edge clear wins over the stored carry being chained in.
          alu_cin_d  = reqChain ? (flag_c_q & ~flagClear) : reqCarry;
          cnt_d      = SETTLE_INIT;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          resp_result_d = aluResult;
          resp_c_d      = aluCarryOut;
          resp_z_d      = aluZero;
          resp_n_d      = aluNegative;
          flag_c_d      = aluCarryOut;
          flag_z_d      = aluZero;
          flag_n_d      = aluNegative;
        end
      end
      RESP: if (respReady) op_count_d = op_count_q + 8'd1;
      default: ;
    endcase
  end

  // NOTE: all datapath registers are reset, since they drive outputs that must read zero under reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_func_q    <= '0;
      alu_cin_q     <= 1'b0;
      resp_result_q <= '0;
      resp_c_q      <= 1'b0;
      resp_z_q      <= 1'b0;
      resp_n_q      <= 1'b0;
      flag_c_q      <= 1'b0;
      flag_z_q      <= 1'b0;
      flag_n_q      <= 1'b0;
      op_count_q    <= '0;
    end else begin
      cnt_q         <= cnt_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_func_q    <= alu_func_d;
      alu_cin_q     <= alu_cin_d;
      resp_result_q <= resp_result_d;
      resp_c_q      <= resp_c_d;
      resp_z_q      <= resp_z_d;
      resp_n_q      <= resp_n_d;
      flag_c_q      <= flag_c_d;
      flag_z_q      <= flag_z_d;
      flag_n_q      <= flag_n_d;
      op_count_q    <= op_count_d;
    end
  end

  assign aluA         = alu_a_q;
  assign aluB         = alu_b_q;
  assign aluFunc      = alu_func_q;
  assign aluCarryIn   = alu_cin_q;
  assign respResult   = resp_result_q;
  assign respCarry    = resp_c_q;
  assign respZero     = resp_z_q;
  assign respNegative = resp_n_q;
  assign flagC        = flag_c_q;
  assign flagZ        = flag_z_q;
  assign flagN        = flag_n_q;
  assign opCount      = op_count_q;

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 1, legal range 1..15: cycles ALU outputs are allowed to settle before capture.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 The block SHALL have port reqValid, input, 1: operation request valid.
REQ-005 The block SHALL have port reqReady, output, 1: block can accept a request.
REQ-006 The block SHALL have ports reqA and reqB, input, 8 each: operands.
REQ-007 The block SHALL have port reqFunc, input, 3: ALU function code, passed through unmodified.
REQ-008 The block SHALL have port reqCarry, input, 1: explicit carry-in.
REQ-009 The block SHALL have port reqChain, input, 1: 1 selects stored flagC as carry-in instead of reqCarry.
REQ-010 The block SHALL have ports aluA and aluB, output, 8 each, and aluFunc, output, 3: drive the ALU inputA, inputB and func.
REQ-011 The block SHALL have port aluCarryIn, output, 1: drives the ALU carryIn.
REQ-012 The block SHALL have ports aluResult, input, 8, and aluCarryOut, aluZero, aluNegative, input, 1 each: ALU outputs.
REQ-013 The block SHALL have port respValid, output, 1, and respReady, input, 1: response handshake.
REQ-014 The block SHALL have port respResult, output, 8, and respCarry, respZero, respNegative, output, 1 each: captured response.
REQ-015 The block SHALL have ports flagC, flagZ, flagN, output, 1 each: status register.
REQ-016 The block SHALL have port flagClear, input, 1: clears the status register.
REQ-017 The block SHALL have port opCount, output, 8: count of completed operations.

Function
REQ-018 The FSM SHALL have states IDLE, SETTLE and RESP; reqReady SHALL be 1 only in IDLE, and respValid SHALL be 1 only in RESP.
REQ-019 In IDLE, when reqValid=1 at an edge (accept), the block SHALL register aluA=reqA, aluB=reqB, aluFunc=reqFunc and aluCarryIn=(reqChain ? flagC : reqCarry), load the settle counter with SETTLE_CYCLES, and enter SETTLE.
REQ-020 In SETTLE the counter SHALL decrement each edge; on the edge where it equals 1, the block SHALL capture aluResult, aluCarryOut, aluZero and aluNegative into the resp* outputs and into flagC, flagZ and flagN, and enter RESP.
REQ-021 Latency: respValid SHALL rise exactly SETTLE_CYCLES edges after the accept edge.
REQ-022 In RESP, resp* SHALL hold stable until an edge with respReady=1; on that edge opCount SHALL increment (8-bit wrap, 255 to 0) and the FSM SHALL return to IDLE.
REQ-023 Requests are accepted only in IDLE, which gives a minimum of SETTLE_CYCLES+2 cycles per operation; reqValid outside IDLE SHALL be ignored.
REQ-024 aluA, aluB, aluFunc and aluCarryIn SHALL stay constant from accept until the next accept, and SHALL retain their values in IDLE.
REQ-025 flagClear SHALL act only in IDLE; it SHALL zero flagC, flagZ and flagN at that edge, and it SHALL be ignored in SETTLE and RESP.
REQ-026 If flagClear and an accept with reqChain=1 occur on the same edge, aluCarryIn SHALL be 0.
REQ-027 resp* SHALL retain the last captured values after returning to IDLE.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, and SHALL zero every registered output, flag, the counter and opCount; reqReady SHALL be 1 and respValid 0 while rst=1 and after release.
REQ-029 Reset mid-operation SHALL abandon the operation with no response and no opCount increment.

Verification (bench models the ALU by driving the alu* inputs directly)
REQ-030 Reset: assert rst during SETTLE -> all outputs 0 and reqReady=1 within the same cycle; no respValid after release.
REQ-031 Single op, SETTLE_CYCLES=1: accept reqA=8'h79, reqB=8'h84, reqFunc=3'b000, reqCarry=1 -> aluA=8'h79, aluB=8'h84, aluCarryIn=1; bench drives aluResult=8'hFE, carry 0, zero 0, negative 1 -> one edge later respValid=1, respResult=8'hFE, flagN=1, flagC=0.
REQ-032 Chain: with flagC=1, accept with reqChain=1 and reqCarry=0 -> aluCarryIn=1; repeat with flagClear=1 on the accept edge -> aluCarryIn=0.
REQ-033 Backpressure: hold respReady=0 for 5 cycles while pulsing reqValid -> resp* stable, reqReady=0, no new accept, opCount unchanged until the respReady edge.
REQ-034 Latency and wrap: SETTLE_CYCLES=3 -> respValid exactly 3 edges after accept; 256 completed operations -> opCount returns to 8'h00.
